cache_fill_fsm: RTL and testbench

Cache fill controller that services a block miss forwarded by the memory/cache arbitration logic. It latches the miss address, issues one read per word of the 8-word block to the multi-cycle memory, and steers each returning word into the cache data array. It writes the tag on the final word and signals completion by dropping `fsm_busy`. One instance sits between the miss arbiter and the unified memory port; the arbiter routes its strobes to whichever cache (I or D) owns the miss.

---
 rtl/cache_fill_fsm.sv | 101 ++++++++++
 tb/tb_cache_fill_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: issues one read per word of the missed block and steers returns into the data array.
// Optional completed-fill counter is built only when CACHE_FILL_MISS_COUNT_EN is defined.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [15:0]       miss_count
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [ADDR_W-OFF_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        recv_cnt_q, recv_cnt_d;
  logic                    issue_done_q, issue_done_d;

  // Only the block-aligned upper address bits are stored; word offsets are concatenated below.
  assign fsm_busy         = (state_q == FILL);
  assign mem_read_en      = fsm_busy & ~issue_done_q;
  assign memory_address   = fsm_busy ? {base_q, issue_cnt_q, 1'b0} : '0;
  assign write_data_array = fsm_busy & memory_data_valid;
  assign write_tag_array  = write_data_array & (recv_cnt_q == LAST_WORD);
  assign fill_address     = fsm_busy ? {base_q, recv_cnt_q, 1'b0} : '0;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    issue_done_d = issue_done_q;
    if (state_q == IDLE) begin
      if (miss_detected) begin
        state_d      = FILL;
        base_d       = miss_address[ADDR_W-1:OFF_W];
        issue_cnt_d  = '0;
        recv_cnt_d   = '0;
        issue_done_d = 1'b0;
      end
    end else begin
      if (mem_read_en) begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (issue_cnt_q == LAST_WORD) issue_done_d = 1'b1;
      end
      if (write_data_array) begin
        recv_cnt_d = recv_cnt_q + CNT_W'(1);
        if (write_tag_array) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      issue_done_q <= issue_done_d;
    end
  end

`ifdef CACHE_FILL_MISS_COUNT_EN
  logic [15:0] miss_count_q;

  // Counts only fills that reach the tag write; a reset-aborted fill never gets there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count_q <= 16'h0000;
    end else if (write_tag_array) begin
      miss_count_q <= miss_count_q + 16'h0001;
    end
  end

  assign miss_count = miss_count_q;
`else
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed 4-cycle memory return schedule.
// Define CACHE_FILL_MISS_COUNT_EN to also exercise the completed-fill counter and its wrap.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] fill_address;
  logic [15:0] miss_count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] expCount = 16'h0000;

`ifdef CACHE_FILL_MISS_COUNT_EN
  localparam logic [15:0] CNT_STEP = 16'h0001;
`else
  localparam logic [15:0] CNT_STEP = 16'h0000;
`endif

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_address      (fill_address),
    .miss_count        (miss_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic miss, input logic [15:0] addr, input logic valid);
    @(posedge clk);
    #1;
    miss_detected     = miss;
    miss_address      = addr;
    memory_data_valid = valid;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"}, fsm_busy, 1'b0);
    checkOutput({tag, ".rd"}, mem_read_en, 1'b0);
    checkOutput({tag, ".maddr"}, memory_address, 16'h0000);
    checkOutput({tag, ".wda"}, write_data_array, 1'b0);
    checkOutput({tag, ".wta"}, write_tag_array, 1'b0);
  endtask

  // Caller drives the sampling cycle (j=0); j counts cycles after that edge.
  // mode 0: miss held; mode 1: miss toggled to 0x4000; mode 2: reset pulled at j=6.
  task automatic runFill(input logic [15:0] addr, input int mode,
                         input logic nextMiss, input logic [15:0] nextAddr);
    logic [15:0] base;
    base = {addr[15:4], 4'h0};
    for (int j = 1; j <= 13; j++) begin
      logic        valid;
      logic        miss;
      logic [15:0] a;
      logic        aborted;
      string       t;
      t       = $sformatf("fill%04h.m%0d.j%0d", addr, mode, j);
      valid   = (j >= 5 && j <= 12);
      miss    = 1'b1;
      a       = addr;
      aborted = (mode == 2 && j >= 6);
      if (mode == 1) begin
        miss = (j % 2 == 1);
        a    = 16'h4000;
      end
      if (aborted) miss = 1'b0;
      if (j == 13) begin
        miss  = nextMiss;
        a     = nextAddr;
        valid = 1'b0;
      end
      applyStimulus(miss, a, valid);
      if (mode == 2 && j == 6) begin
        #1 rst_n = 1'b0;
        #1;
      end else begin
        @(negedge clk);
      end
      if (aborted || j == 13) begin
        checkIdle(t);
      end else begin
        checkOutput({t, ".busy"}, fsm_busy, 1'b1);
        checkOutput({t, ".rd"}, mem_read_en, (j <= 8));
        if (j <= 8) checkOutput({t, ".maddr"}, memory_address, base + 16'(2 * (j - 1)));
        checkOutput({t, ".wda"}, write_data_array, (j >= 5));
        if (j >= 5) checkOutput({t, ".faddr"}, fill_address, base + 16'(2 * (j - 5)));
        checkOutput({t, ".wta"}, write_tag_array, (j == 12));
      end
      if (j == 12 && !aborted) checkOutput({t, ".cnt"}, miss_count, expCount);
      if (j == 13) begin
        if (mode != 2) expCount = expCount + CNT_STEP;
        checkOutput({t, ".cnt"}, miss_count, expCount);
      end
      if (mode == 2 && j == 7) rst_n = 1'b1;
    end
  endtask

  initial begin
    memory_data_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset.faddr", fill_address, 16'h0000);
    checkOutput("reset.cnt", miss_count, 16'h0000);
    rst_n = 1'b1;

    // Aborted fill runs first so the counter is zero regardless of reset clearing it.
    applyStimulus(1'b1, 16'h3333, 1'b0);
    @(negedge clk);
    checkIdle("abort.sample");
    runFill(16'h3333, 2, 1'b0, 16'h0000);

    applyStimulus(1'b1, 16'h1236, 1'b0);
    runFill(16'h1236, 0, 1'b0, 16'h0000);

    applyStimulus(1'b1, 16'h1236, 1'b0);
    runFill(16'h1236, 1, 1'b0, 16'h0000);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 16'h5555, 1'b1);
      @(negedge clk);
      checkIdle($sformatf("stray%0d", k));
    end

    applyStimulus(1'b1, 16'h2A5C, 1'b0);
    runFill(16'h2A5C, 0, 1'b0, 16'h0000);

    applyStimulus(1'b1, 16'h0010, 1'b0);
    runFill(16'h0010, 0, 1'b1, 16'hFFF0);
    runFill(16'hFFF0, 0, 1'b0, 16'h0000);

`ifdef CACHE_FILL_MISS_COUNT_EN
    @(negedge clk);
    force dut.miss_count_q = 16'hFFFF;
    #1;
    release dut.miss_count_q;
    expCount = 16'hFFFF;
    @(negedge clk);
    checkOutput("wrap.pre", miss_count, 16'hFFFF);
    applyStimulus(1'b1, 16'h0800, 1'b0);
    runFill(16'h0800, 0, 1'b0, 16'h0000);
    checkOutput("wrap.post", miss_count, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
